// File: rtl/cp0_except_unit.sv
// rtl/cp0_except_unit.sv - MEM-stage CP0 register file and exception arbiter.
// Optional timer (Count/Compare, timer interrupt) enabled by defining CP0_TIMER_EN.
module cp0_except_unit #(
  parameter logic [31:0] PRID       = 32'h0000_4220,
  parameter logic [31:0] CONFIG     = 32'h0000_0000,
  parameter int          COUNT_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_addr_i,
  input  logic [8:0]  mem_exc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [4:0]  cp0_raddr_i,
  input  logic [5:0]  int_i,
  output logic [31:0] cp0_rdata_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic [31:0] STATUS_MASK = 32'h0000_ff03;

  typedef enum logic [1:0] {BV_NONE, BV_PC, BV_ADDR} bv_src_e;

  logic [31:0] status, cause, epc, badvaddr, count, compare;
  logic        timer_int;
  logic        take, int_pend, exc_commit, eret_commit, wr_ok;
  logic [31:0] et;
  logic [4:0]  exc_code;
  bv_src_e     bv_src;

  assign take     = mem_valid_i & ~flush_i;
  assign int_pend = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));

  always_comb begin
    et     = 32'h0;
    bv_src = BV_NONE;
    if (rst && take) begin
      if (int_pend)          et = 32'h1;
      else if (mem_exc_i[0]) begin et = 32'h4; bv_src = BV_PC; end
      else if (mem_exc_i[1]) et = 32'ha;
      else if (mem_exc_i[2]) et = 32'hc;
      else if (mem_exc_i[3]) et = 32'hd;
      else if (mem_exc_i[4]) et = 32'h8;
      else if (mem_exc_i[5]) et = 32'h9;
      else if (mem_exc_i[6]) begin et = 32'h4; bv_src = BV_ADDR; end
      else if (mem_exc_i[7]) begin et = 32'h5; bv_src = BV_ADDR; end
      else if (mem_exc_i[8]) et = 32'he;
    end
  end

  // Except for interrupts, the ExcCode equals the low bits of the excepttype code.
  assign exc_code    = (et == 32'h1) ? 5'd0 : et[4:0];
  assign exc_commit  = (et != 32'h0) && (et != 32'he);
  assign eret_commit = (et == 32'he);
  assign wr_ok       = cp0_we_i && (et == 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= STATUS_RST;
      cause    <= 32'h0;
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else begin
      cause[15:10] <= {int_i[5] | timer_int, int_i[4:0]};
      if (exc_commit) begin
        if (!status[1]) begin
          epc       <= mem_in_ds_i ? mem_pc_i - 32'd4 : mem_pc_i;
          cause[31] <= mem_in_ds_i;
        end
        status[1]  <= 1'b1;
        cause[6:2] <= exc_code;
        if (bv_src == BV_PC)        badvaddr <= mem_pc_i;
        else if (bv_src == BV_ADDR) badvaddr <= mem_addr_i;
      end else if (eret_commit) begin
        status[1] <= 1'b0;
      end else if (wr_ok) begin
        case (cp0_waddr_i)
          5'd12:   status     <= (status & ~STATUS_MASK) | (cp0_wdata_i & STATUS_MASK);
          5'd13:   cause[9:8] <= cp0_wdata_i[9:8];
          5'd14:   epc        <= cp0_wdata_i;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  localparam int TW = (COUNT_LOG2 > 0) ? COUNT_LOG2 : 1;
  logic [TW-1:0] tick;
  logic          tick_wrap;

  assign tick_wrap = (COUNT_LOG2 == 0) || (tick == {TW{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= 32'h0;
      compare   <= 32'h0;
      tick      <= '0;
      timer_int <= 1'b0;
    end else begin
      if (wr_ok && cp0_waddr_i == 5'd9) begin
        count <= cp0_wdata_i;
        tick  <= '0;
      end else begin
        tick <= tick + 1'b1;
        if (tick_wrap) count <= count + 32'd1;
      end
      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (wr_ok && cp0_waddr_i == 5'd11) begin
        compare   <= cp0_wdata_i;
        timer_int <= 1'b0;
      end else if (compare != 32'h0 && count == compare) begin
        timer_int <= 1'b1;
      end
    end
  end
`else
  assign count     = 32'h0;
  assign compare   = 32'h0;
  assign timer_int = 1'b0;
`endif

  always_comb begin
    cp0_rdata_o = 32'h0;
    case (cp0_raddr_i)
      5'd8:    cp0_rdata_o = badvaddr;
      5'd9:    cp0_rdata_o = count;
      5'd11:   cp0_rdata_o = compare;
      5'd12:   cp0_rdata_o = status;
      5'd13:   cp0_rdata_o = cause;
      5'd14:   cp0_rdata_o = epc;
      5'd15:   cp0_rdata_o = PRID;
      5'd16:   cp0_rdata_o = CONFIG;
      default: cp0_rdata_o = 32'h0;
    endcase
  end

  assign excepttype_o = et;
  assign cp0_epc_o    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc;
  assign status_o     = status;
  assign cause_o      = cause;
  assign timer_int_o  = timer_int;

endmodule
